// File: rtl/buf_burst_reader.sv
// Read side of the burst buffer: drains DEPTH entries in address order onto a
// valid/ready stream, then pulses burst_ack to release the buffer to the writer.
module buf_burst_reader #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          burst_rdy,
  output logic          burst_ack,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          dout_last,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ACK} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        r_state, w_nxt;
  logic [AW-1:0] r_cnt, r_addr;
  logic [DW-1:0] r_dout;
  logic          r_vld, r_ack;
  logic          w_hs, w_end;

  assign w_hs  = r_vld & dout_rdy;
  assign w_end = w_hs & (r_cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (burst_rdy) w_nxt = S_STREAM;
      S_STREAM: if (w_end)     w_nxt = S_ACK;
      S_ACK:                   w_nxt = S_IDLE;
      default:                 w_nxt = S_IDLE;
    endcase
  end

  // rd_addr runs one entry ahead of cnt so rd_data is ready at each handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (burst_rdy) begin
            r_dout <= rd_data;
            r_vld  <= 1'b1;
            r_cnt  <= '0;
            r_addr <= AW'(1);
          end
        end
        S_STREAM: begin
          if (w_end) begin
            r_vld  <= 1'b0;
            r_ack  <= 1'b1;
            r_cnt  <= '0;
            r_addr <= '0;
          end else if (w_hs) begin
            r_dout <= rd_data;
            r_cnt  <= r_cnt + AW'(1);
            r_addr <= r_addr + AW'(1);
          end
        end
        S_ACK: r_ack <= 1'b0;
        default: ;
      endcase
    end
  end

  assign burst_ack = r_ack;
  assign rd_addr   = r_addr;
  assign dout      = r_dout;
  assign dout_vld  = r_vld;
  assign dout_last = r_vld & (r_cnt == LAST);
  assign busy      = (r_state != S_IDLE);

endmodule
